// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_send byte transmitter among NUM_REQ
// valid/ready byte streams; packets go out whole, paced by uart_tx_busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 0,
  parameter int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_din,
  input  logic                 uart_tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 tx_err
);

  localparam int TO_LAST  = (BUSY_TIMEOUT > 1) ? BUSY_TIMEOUT - 1 : 0;
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
  localparam int CNT_MAX  = (TO_LAST > GAP_LAST) ? TO_LAST : GAP_LAST;
  localparam int CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [CNT_W-1:0]     cnt;
  logic                 last_q;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_id;
  logic [NUM_REQ-1:0]   grant_oh;
  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) return '0;
    return id + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] rot_add(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Rotate the valid vector so bit 0 is the requester at ptr; the lowest set
  // bit of the rotated vector is then the round-robin winner.
  assign valid_dbl = {req_valid, req_valid} >> ptr;
  assign valid_rot = valid_dbl[NUM_REQ-1:0];

  // NOTE: every variable written here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_found = |valid_rot;
    pick_id    = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) pick_id = rot_add(ptr, k);
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = (grant_id == ID_W'(i));
      if (grant_id == ID_W'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  assign sel_valid = |(req_valid & grant_oh);
  assign sel_last  = |(req_last & grant_oh);
  assign req_ready = (state == ACCEPT) ? grant_oh : '0;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      last_q     <= 1'b0;
      grant_id   <= '0;
      uart_tx_en <= 1'b0;
      uart_din   <= 8'h00;
      tx_err     <= 1'b0;
    end else begin
      uart_tx_en <= 1'b0;
      tx_err     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            state    <= ACCEPT;
          end
        end
        ACCEPT: begin
          // A stalled owner keeps the port; nobody else is considered here.
          if (sel_valid) begin
            uart_din   <= sel_data;
            last_q     <= sel_last;
            uart_tx_en <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(TO_LAST)) begin
            tx_err <= 1'b1;
            ptr    <= next_id(grant_id);
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (GAP_CYCLES > 0) begin
              cnt   <= '0;
              state <= GAP;
            end else if (last_q) begin
              ptr   <= next_id(grant_id);
              state <= IDLE;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_LAST)) begin
            if (last_q) begin
              ptr   <= next_id(grant_id);
              state <= IDLE;
            end else begin
              state <= ACCEPT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (no gap / 5-cycle gap),
// each with its own uart_send busy model, requester queues and event log.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int NI = 2;
  localparam int LOG_D = 16;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } byte_t;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic [NR-1:0]   req_valid    [NI];
  logic [8*NR-1:0] req_data     [NI];
  logic [NR-1:0]   req_last     [NI];
  logic [NR-1:0]   req_ready    [NI];
  logic            uart_tx_en   [NI];
  logic [7:0]      uart_din     [NI];
  logic            uart_tx_busy [NI];
  logic [1:0]      grant_id     [NI];
  logic            tx_err       [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  byte_t src_mem [NI][NR][8];
  int    src_len [NI][NR];
  int    src_pos [NI][NR];
  bit    stall   [NI][NR];
  bit    acc     [NI][NR];
  int    hs_cnt  [NI][NR];
  int    last_hs_cyc   [NI][NR];
  int    first_rdy_cyc [NI][NR];

  bit   model_on   [NI];
  int   busy_delay [NI];
  int   busy_len   [NI];
  int   m_wait     [NI];
  int   m_hold     [NI];

  int         ev_n   [NI];
  logic [7:0] ev_din [NI][LOG_D];
  logic [1:0] ev_gid [NI][LOG_D];
  int         ev_cyc [NI][LOG_D];
  int         ev_gap [NI][LOG_D];
  int         last_fall    [NI];
  int         err_n        [NI];
  int         err_cyc      [NI];
  int         en_double    [NI];
  int         err_double   [NI];
  int         din_busy_chg [NI];
  logic       en_prev   [NI];
  logic       err_prev  [NI];
  logic       busy_prev [NI];
  logic [7:0] din_prev  [NI];

  logic [7:0] exp_din [8];
  logic [1:0] exp_gid [8];

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(16), .GAP_CYCLES(0)) dut0 (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req_valid    (req_valid[0]),
    .req_data     (req_data[0]),
    .req_last     (req_last[0]),
    .req_ready    (req_ready[0]),
    .uart_tx_en   (uart_tx_en[0]),
    .uart_din     (uart_din[0]),
    .uart_tx_busy (uart_tx_busy[0]),
    .grant_id     (grant_id[0]),
    .tx_err       (tx_err[0])
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(16), .GAP_CYCLES(5)) dut1 (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req_valid    (req_valid[1]),
    .req_data     (req_data[1]),
    .req_last     (req_last[1]),
    .req_ready    (req_ready[1]),
    .uart_tx_en   (uart_tx_en[1]),
    .uart_din     (uart_din[1]),
    .uart_tx_busy (uart_tx_busy[1]),
    .grant_id     (grant_id[1]),
    .tx_err       (tx_err[1])
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: sample everything on the falling edge, well away from the DUT edge.
  always @(negedge sys_clk) begin
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < NR; i++) begin
        acc[k][i] = req_valid[k][i] && req_ready[k][i];
        if (acc[k][i]) begin
          hs_cnt[k][i]++;
          last_hs_cyc[k][i] = cyc;
        end
        if (req_ready[k][i] && first_rdy_cyc[k][i] < 0) first_rdy_cyc[k][i] = cyc;
      end
      if (busy_prev[k] && !uart_tx_busy[k]) last_fall[k] = cyc;
      if (uart_tx_en[k]) begin
        if (en_prev[k]) en_double[k]++;
        if (ev_n[k] < LOG_D) begin
          ev_din[k][ev_n[k]] = uart_din[k];
          ev_gid[k][ev_n[k]] = grant_id[k];
          ev_cyc[k][ev_n[k]] = cyc;
          ev_gap[k][ev_n[k]] = cyc - last_fall[k];
        end
        ev_n[k]++;
      end
      if (tx_err[k]) begin
        if (err_prev[k]) err_double[k]++;
        if (err_n[k] == 0) err_cyc[k] = cyc;
        err_n[k]++;
      end
      if (uart_tx_busy[k] && uart_din[k] != din_prev[k]) din_busy_chg[k]++;
      en_prev[k]   = uart_tx_en[k];
      err_prev[k]  = tx_err[k];
      busy_prev[k] = uart_tx_busy[k];
      din_prev[k]  = uart_din[k];
    end
  end

  // Requester sources and uart_send busy model, driven 1 time unit after the edge.
  always @(posedge sys_clk) begin
    #1;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (acc[k][i]) src_pos[k][i]++;
        acc[k][i] = 1'b0;
        if (!stall[k][i] && src_pos[k][i] < src_len[k][i]) begin
          req_valid[k][i]       = 1'b1;
          req_data[k][8*i +: 8] = src_mem[k][i][src_pos[k][i]].data;
          req_last[k][i]        = src_mem[k][i][src_pos[k][i]].last;
        end else begin
          req_valid[k][i]       = 1'b0;
          req_data[k][8*i +: 8] = 8'h00;
          req_last[k][i]        = 1'b0;
        end
      end
      if (m_wait[k] > 0) begin
        m_wait[k]--;
        if (m_wait[k] == 0) begin
          uart_tx_busy[k] = 1'b1;
          m_hold[k]       = busy_len[k];
        end
      end else if (m_hold[k] > 0) begin
        m_hold[k]--;
        if (m_hold[k] == 0) uart_tx_busy[k] = 1'b0;
      end else if (model_on[k] && uart_tx_en[k]) begin
        m_wait[k] = busy_delay[k];
      end
    end
  end

  task automatic clear_log(input int k);
    ev_n[k] = 0;
    err_n[k] = 0;
    err_cyc[k] = -1;
    en_double[k] = 0;
    err_double[k] = 0;
    din_busy_chg[k] = 0;
    for (int i = 0; i < NR; i++) begin
      hs_cnt[k][i] = 0;
      last_hs_cyc[k][i] = -1;
      first_rdy_cyc[k][i] = -1;
    end
  endtask

  task automatic clear_tb();
    for (int k = 0; k < NI; k++) begin
      clear_log(k);
      for (int i = 0; i < NR; i++) begin
        src_len[k][i] = 0;
        src_pos[k][i] = 0;
        stall[k][i]   = 1'b0;
        acc[k][i]     = 1'b0;
      end
      model_on[k] = 1'b1;
      busy_delay[k] = 3;
      busy_len[k] = 4;
      m_wait[k] = 0;
      m_hold[k] = 0;
      uart_tx_busy[k] = 1'b0;
      req_valid[k] = '0;
      req_data[k] = '0;
      req_last[k] = '0;
      last_fall[k] = 0;
      en_prev[k] = 1'b0;
      err_prev[k] = 1'b0;
      busy_prev[k] = 1'b0;
      din_prev[k] = 8'h00;
    end
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    clear_tb();
    repeat (2) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
  endtask

  task automatic push(input int k, input int i, input logic last, input logic [7:0] data);
    src_mem[k][i][src_len[k][i]] = {last, data};
    src_len[k][i]++;
  endtask

  task automatic wait_ev(input int k, input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (ev_n[k] < n && t < budget) begin
      @(negedge sys_clk);
      #1;
      t++;
    end
    if (ev_n[k] < n) check({tag, "_en_timeout"}, ev_n[k], n);
  endtask

  task automatic wait_hs(input int k, input int i, input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (hs_cnt[k][i] < n && t < budget) begin
      @(negedge sys_clk);
      #1;
      t++;
    end
    if (hs_cnt[k][i] < n) check({tag, "_hs_timeout"}, hs_cnt[k][i], n);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_tb();
    sys_rst_n = 1'b1;

    // Reset values, checked before any clock edge to show the reset is asynchronous.
    #3 sys_rst_n = 1'b0;
    #1;
    check("rst_en",    32'(uart_tx_en[0]), 0);
    check("rst_din",   32'(uart_din[0]),   0);
    check("rst_ready", 32'(req_ready[0]),  0);
    check("rst_gid",   32'(grant_id[0]),   0);
    check("rst_err",   32'(tx_err[0]),     0);
    check("rst_ready_g", 32'(req_ready[1]), 0);
    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;

    // Single byte: busy rises 3 cycles after en and stays high 100 cycles.
    busy_delay[0] = 3;
    busy_len[0]   = 100;
    push(0, 0, 1'b1, 8'hA5);
    wait_ev(0, 1, 20, "single");
    run(120);
    check("single_en_count", ev_n[0], 1);
    check("single_din",      32'(ev_din[0][0]), 32'hA5);
    check("single_gid",      32'(ev_gid[0][0]), 0);
    check("single_en_width", en_double[0], 0);
    check("single_hs",       hs_cnt[0][0], 1);
    check("single_din_hold", 32'(uart_din[0]), 32'hA5);
    check("single_din_busy", din_busy_chg[0], 0);
    check("single_idle_rdy", 32'(req_ready[0]), 0);

    // Packet lock: ptr is 1 now, req1 owns the port for 11,22,33 before req2's 44.
    clear_log(0);
    busy_delay[0] = 2;
    busy_len[0]   = 4;
    push(0, 1, 1'b0, 8'h11);
    push(0, 1, 1'b0, 8'h22);
    push(0, 1, 1'b1, 8'h33);
    push(0, 2, 1'b1, 8'h44);
    wait_ev(0, 4, 200, "lock");
    run(20);
    exp_din[0] = 8'h11; exp_din[1] = 8'h22; exp_din[2] = 8'h33; exp_din[3] = 8'h44;
    exp_gid[0] = 2'd1;  exp_gid[1] = 2'd1;  exp_gid[2] = 2'd1;  exp_gid[3] = 2'd2;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("lock_din%0d", j), 32'(ev_din[0][j]), 32'(exp_din[j]));
      check($sformatf("lock_gid%0d", j), 32'(ev_gid[0][j]), 32'(exp_gid[j]));
    end
    check("lock_ready2_after_pkt", 32'(first_rdy_cyc[0][2] > last_hs_cyc[0][1]), 1);
    check("lock_next_byte_lat", ev_gap[0][1], 2);
    check("lock_en_width", en_double[0], 0);
    check("lock_din_busy", din_busy_chg[0], 0);

    // Round robin: everyone valid with single-byte packets, starting from ptr 0.
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      push(0, i, 1'b1, 8'hA0 + 8'(i));
      push(0, i, 1'b1, 8'hB0 + 8'(i));
    end
    wait_ev(0, 8, 400, "rr");
    for (int j = 0; j < 6; j++) begin
      check($sformatf("rr_gid%0d", j), 32'(ev_gid[0][j]), j % 4);
      check($sformatf("rr_din%0d", j), 32'(ev_din[0][j]),
            (j < 4) ? 32'hA0 + j : 32'hB0 + j - 4);
    end
    check("rr_idle_to_en_lat", ev_gap[0][1], 3);

    // Busy timeout: the model never answers; req0's rest of packet is skipped.
    apply_reset();
    model_on[0] = 1'b0;
    push(0, 0, 1'b0, 8'h55);
    push(0, 0, 1'b1, 8'h66);
    push(0, 1, 1'b1, 8'h77);
    wait_ev(0, 2, 100, "tmo");
    check("tmo_err_delay",  err_cyc[0] - ev_cyc[0][0], 17);
    check("tmo_err_once",   err_n[0], 1);
    check("tmo_err_width",  err_double[0], 0);
    check("tmo_next_gid",   32'(ev_gid[0][1]), 1);
    check("tmo_next_din",   32'(ev_din[0][1]), 32'h77);
    check("tmo_next_lat",   ev_cyc[0][1] - ev_cyc[0][0], 19);

    // Gap and stall on the GAP_CYCLES=5 instance.
    apply_reset();
    busy_delay[1] = 2;
    busy_len[1]   = 6;
    push(1, 0, 1'b0, 8'hC1);
    push(1, 0, 1'b0, 8'hC2);
    push(1, 0, 1'b1, 8'hC3);
    push(1, 3, 1'b1, 8'hD3);
    wait_hs(1, 0, 1, 30, "gap");
    stall[1][0] = 1'b1;
    run(20);
    check("stall_no_en",      ev_n[1], 1);
    check("stall_owner_rdy",  32'(req_ready[1][0]), 1);
    check("stall_gid",        32'(grant_id[1]), 0);
    check("stall_req3_hs",    hs_cnt[1][3], 0);
    check("stall_req3_rdy",   first_rdy_cyc[1][3], -1);
    stall[1][0] = 1'b0;
    wait_ev(1, 4, 300, "gap");
    exp_din[0] = 8'hC1; exp_din[1] = 8'hC2; exp_din[2] = 8'hC3; exp_din[3] = 8'hD3;
    for (int j = 0; j < 4; j++)
      check($sformatf("gap_din%0d", j), 32'(ev_din[1][j]), 32'(exp_din[j]));
    check("gap_last_gid",   32'(ev_gid[1][3]), 3);
    check("gap_min_c3",     32'(ev_gap[1][2] >= 6), 1);
    check("gap_max_c3",     32'(ev_gap[1][2] <= 7), 1);
    check("gap_min_d3",     32'(ev_gap[1][3] >= 6), 1);
    check("gap_en_width",   en_double[1], 0);
    check("gap_din_busy",   din_busy_chg[1], 0);

    // Reset during WAIT_DONE; req1 completes first so ptr is 2 when req2 is cut off.
    apply_reset();
    busy_delay[0] = 2;
    busy_len[0]   = 30;
    push(0, 1, 1'b1, 8'h5A);
    wait_ev(0, 1, 20, "mid1");
    run(45);
    push(0, 2, 1'b1, 8'hE2);
    wait_ev(0, 2, 20, "mid2");
    run(6);
    check("mid_pre_din",  32'(uart_din[0]), 32'hE2);
    check("mid_pre_gid",  32'(grant_id[0]), 2);
    check("mid_pre_busy", 32'(uart_tx_busy[0]), 1);
    #1 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_en",    32'(uart_tx_en[0]), 0);
    check("mid_rst_din",   32'(uart_din[0]),   0);
    check("mid_rst_ready", 32'(req_ready[0]),  0);
    check("mid_rst_gid",   32'(grant_id[0]),   0);
    check("mid_rst_err",   32'(tx_err[0]),     0);
    clear_tb();
    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    push(0, 3, 1'b1, 8'hF3);
    push(0, 0, 1'b1, 8'hF0);
    wait_ev(0, 2, 100, "restart");
    check("restart_gid0", 32'(ev_gid[0][0]), 0);
    check("restart_din0", 32'(ev_din[0][0]), 32'hF0);
    check("restart_gid1", 32'(ev_gid[0][1]), 3);
    check("restart_din1", 32'(ev_din[0][1]), 32'hF3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
